// File: rtl/cu_setup_sequencer_pkg.sv
// Shared definitions for the CU setup sequencer.
// - One-hot state encodings (as plain constants and as the cu_setup_seq_state enum).
// - Width helpers for the outstanding counter and the per-channel word index.
package cu_setup_sequencer_pkg;

    localparam logic [9:0] ST_RESET       = 10'b00_0000_0001;
    localparam logic [9:0] ST_IDLE        = 10'b00_0000_0010;
    localparam logic [9:0] ST_REQ_START   = 10'b00_0000_0100;
    localparam logic [9:0] ST_REQ_BUSY    = 10'b00_0000_1000;
    localparam logic [9:0] ST_REQ_PAUSE   = 10'b00_0001_0000;
    localparam logic [9:0] ST_REQ_DONE    = 10'b00_0010_0000;
    localparam logic [9:0] ST_FLUSH_START = 10'b00_0100_0000;
    localparam logic [9:0] ST_FLUSH_BUSY  = 10'b00_1000_0000;
    localparam logic [9:0] ST_FLUSH_PAUSE = 10'b01_0000_0000;
    localparam logic [9:0] ST_FLUSH_DONE  = 10'b10_0000_0000;

    typedef enum logic [9:0] {
        StReset      = ST_RESET,
        StIdle       = ST_IDLE,
        StReqStart   = ST_REQ_START,
        StReqBusy    = ST_REQ_BUSY,
        StReqPause   = ST_REQ_PAUSE,
        StReqDone    = ST_REQ_DONE,
        StFlushStart = ST_FLUSH_START,
        StFlushBusy  = ST_FLUSH_BUSY,
        StFlushPause = ST_FLUSH_PAUSE,
        StFlushDone  = ST_FLUSH_DONE
    } cu_setup_seq_state;

    // Bits needed to hold 0..max_out inclusive.
    function automatic int unsigned cu_setup_cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    // Index width within a channel; at least one bit so ports stay legal.
    function automatic int unsigned cu_setup_idx_width(input int unsigned words_per_channel);
        return (words_per_channel > 1) ? $clog2(words_per_channel) : 1;
    endfunction

endpackage

// File: rtl/cu_setup_sequencer_if.sv
// Memory read channel between the setup sequencer (master) and memory (slave).
// - req_valid_out/req_ready_in/req_addr_out : read request handshake
// - resp_valid_in/resp_data_in              : in-order read response, always accepted
interface cu_setup_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  req_valid_out;
    logic                  req_ready_in;
    logic [ADDR_WIDTH-1:0] req_addr_out;
    logic                  resp_valid_in;
    logic [DATA_WIDTH-1:0] resp_data_in;

    modport master (
        output req_valid_out,
        output req_addr_out,
        input  req_ready_in,
        input  resp_valid_in,
        input  resp_data_in
    );

    modport slave (
        input  req_valid_out,
        input  req_addr_out,
        output req_ready_in,
        output resp_valid_in,
        output resp_data_in
    );
endinterface

// File: rtl/cu_setup_resp_router.sv
// Routes accepted read responses to the per-channel configuration ports.
// - clear        : accepted start; resets the response count and the error flag
// - resp_allowed : a response may be accepted (reads in flight, not idle/reset)
// - resp_valid/resp_data : raw response channel
// - resp_accept  : response consumed this cycle (feeds the outstanding counter)
// - cfg_valid/cfg_index/cfg_data : registered one-hot strobe, index and word
// - error        : sticky flag for responses that arrive when none is expected
module cu_setup_resp_router
    import cu_setup_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned WORDS_PER_CHANNEL = 8,
    parameter int unsigned COUNT_WIDTH       = 16
) (
    input  logic                                                ap_clk,
    input  logic                                                ap_rst_n,
    input  logic                                                clear,
    input  logic                                                resp_allowed,
    input  logic                                                resp_valid,
    input  logic [DATA_WIDTH-1:0]                               resp_data,
    output logic                                                resp_accept,
    output logic [NUM_CHANNELS-1:0]                             cfg_valid,
    output logic [cu_setup_idx_width(WORDS_PER_CHANNEL)-1:0]    cfg_index,
    output logic [DATA_WIDTH-1:0]                               cfg_data,
    output logic                                                error
);
    localparam int unsigned IdxW     = cu_setup_idx_width(WORDS_PER_CHANNEL);
    localparam int unsigned IdxShift = $clog2(WORDS_PER_CHANNEL);
    localparam logic [COUNT_WIDTH-1:0] IdxMask = COUNT_WIDTH'(WORDS_PER_CHANNEL - 1);

    logic [COUNT_WIDTH-1:0]  resp_cnt_q;
    logic [COUNT_WIDTH-1:0]  chan;
    logic [NUM_CHANNELS-1:0] cfg_valid_d, cfg_valid_q;
    logic [IdxW-1:0]         cfg_index_q;
    logic [DATA_WIDTH-1:0]   cfg_data_q;
    logic                    error_q;

    assign resp_accept = resp_valid && resp_allowed;
    // WORDS_PER_CHANNEL is a power of two, so the divide is a shift.
    assign chan        = resp_cnt_q >> IdxShift;

    always_comb begin
        cfg_valid_d = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (chan == COUNT_WIDTH'(c)) begin
                cfg_valid_d[c] = resp_accept;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            resp_cnt_q  <= '0;
            cfg_valid_q <= '0;
            cfg_index_q <= '0;
            cfg_data_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            cfg_valid_q <= cfg_valid_d;
            if (resp_accept) begin
                cfg_index_q <= IdxW'(resp_cnt_q & IdxMask);
                cfg_data_q  <= resp_data;
            end
            if (clear) begin
                resp_cnt_q <= '0;
            end else if (resp_accept) begin
                resp_cnt_q <= resp_cnt_q + COUNT_WIDTH'(1);
            end
            // A stray response outranks the clear so it is never lost.
            if (resp_valid && !resp_allowed) begin
                error_q <= 1'b1;
            end else if (clear) begin
                error_q <= 1'b0;
            end
        end
    end

    assign cfg_valid = cfg_valid_q;
    assign cfg_index = cfg_index_q;
    assign cfg_data  = cfg_data_q;
    assign error     = error_q;

endmodule

// File: rtl/cu_setup_sequencer.sv
// CU setup sequencer: fetches a block of configuration words and distributes them
// across NUM_CHANNELS engine configuration ports, then drains in-flight reads.
// - ap_clk/ap_rst_n : clock, asynchronous active-low reset
// - start_in/pause_in : start pulse (honoured in IDLE only), host pause level
// - cfg_base_addr_in/cfg_num_words_in : block base and length, latched on start
// - mem : read request/response channel (master side)
// - cfg_valid_out/cfg_index_out/cfg_data_out : per-channel configuration writes
// - busy_out/done_out/error_out/state_out : status
module cu_setup_sequencer
    import cu_setup_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH        = 64,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned WORDS_PER_CHANNEL = 8,
    parameter int unsigned MAX_OUTSTANDING   = 16,
    parameter int unsigned COUNT_WIDTH       = 16
) (
    input  logic                                             ap_clk,
    input  logic                                             ap_rst_n,
    input  logic                                             start_in,
    input  logic                                             pause_in,
    input  logic [ADDR_WIDTH-1:0]                            cfg_base_addr_in,
    input  logic [COUNT_WIDTH-1:0]                           cfg_num_words_in,
    cu_setup_sequencer_if.master                             mem,
    output logic [NUM_CHANNELS-1:0]                          cfg_valid_out,
    output logic [cu_setup_idx_width(WORDS_PER_CHANNEL)-1:0] cfg_index_out,
    output logic [DATA_WIDTH-1:0]                            cfg_data_out,
    output logic                                             busy_out,
    output logic                                             done_out,
    output logic                                             error_out,
    output logic [9:0]                                       state_out
);
    localparam int unsigned OutW = cu_setup_cnt_width(MAX_OUTSTANDING);
    localparam logic [COUNT_WIDTH-1:0] MaxWords = COUNT_WIDTH'(NUM_CHANNELS * WORDS_PER_CHANNEL);
    localparam logic [OutW-1:0]        MaxOut   = OutW'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0]  Stride   = ADDR_WIDTH'(DATA_WIDTH / 8);

    cu_setup_seq_state state_q, state_d;

    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] num_words_q, num_words_d;
    logic [COUNT_WIDTH-1:0] issued_q, issued_d;
    logic [OutW-1:0]        out_q, out_d;
    logic                   req_valid_q, req_valid_d;
    logic                   start_ok, req_hs, resp_allowed, resp_accept;

    assign start_ok     = (state_q == StIdle) && start_in;
    assign req_hs       = req_valid_q && mem.req_ready_in;
    assign resp_allowed = (out_q != '0) && (state_q != StIdle) && (state_q != StReset);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:    state_d = StIdle;
            StIdle:     if (start_in) state_d = StReqStart;
            StReqStart: state_d = (num_words_q == '0) ? StReqDone : StReqBusy;
            StReqBusy: begin
                // A pending request must complete before pausing.
                if (req_hs && (issued_q + COUNT_WIDTH'(1) == num_words_q)) begin
                    state_d = StReqDone;
                end else if (pause_in && (!req_valid_q || req_hs)) begin
                    state_d = StReqPause;
                end
            end
            StReqPause:   if (!pause_in) state_d = StReqBusy;
            StReqDone:    state_d = StFlushStart;
            StFlushStart: state_d = StFlushBusy;
            StFlushBusy: begin
                if (out_q == '0) begin
                    state_d = StFlushDone;
                end else if (pause_in) begin
                    state_d = StFlushPause;
                end
            end
            StFlushPause: if (!pause_in) state_d = StFlushBusy;
            StFlushDone:  state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        num_words_d = num_words_q;
        issued_d    = issued_q;
        out_d       = out_q;
        if (start_ok) begin
            addr_d      = cfg_base_addr_in;
            num_words_d = (cfg_num_words_in > MaxWords) ? MaxWords : cfg_num_words_in;
            issued_d    = '0;
            out_d       = '0;
        end else begin
            if (req_hs) begin
                issued_d = issued_q + COUNT_WIDTH'(1);
                addr_d   = addr_q + Stride;
            end
            unique case ({req_hs, resp_accept})
                2'b10:   out_d = out_q + OutW'(1);
                2'b01:   out_d = out_q - OutW'(1);
                default: out_d = out_q;
            endcase
        end

        // Raise against next-cycle counts so back-to-back requests never overshoot
        // the credit limit or the word count.
        req_valid_d = 1'b0;
        if ((state_q == StReqBusy) && req_valid_q && !mem.req_ready_in) begin
            req_valid_d = 1'b1;
        end else if ((state_d == StReqBusy) && !pause_in && (issued_d < num_words_d) &&
                     (out_d < MaxOut)) begin
            req_valid_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StReset;
            addr_q      <= '0;
            num_words_q <= '0;
            issued_q    <= '0;
            out_q       <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            num_words_q <= num_words_d;
            issued_q    <= issued_d;
            out_q       <= out_d;
            req_valid_q <= req_valid_d;
        end
    end

    cu_setup_resp_router #(
        .DATA_WIDTH        (DATA_WIDTH),
        .NUM_CHANNELS      (NUM_CHANNELS),
        .WORDS_PER_CHANNEL (WORDS_PER_CHANNEL),
        .COUNT_WIDTH       (COUNT_WIDTH)
    ) u_router (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .clear        (start_ok),
        .resp_allowed (resp_allowed),
        .resp_valid   (mem.resp_valid_in),
        .resp_data    (mem.resp_data_in),
        .resp_accept  (resp_accept),
        .cfg_valid    (cfg_valid_out),
        .cfg_index    (cfg_index_out),
        .cfg_data     (cfg_data_out),
        .error        (error_out)
    );

    assign mem.req_valid_out = req_valid_q;
    assign mem.req_addr_out  = addr_q;
    assign state_out         = state_q;
    assign busy_out          = !((state_q == StReset) || (state_q == StIdle) ||
                                 (state_q == StFlushDone));
    assign done_out          = (state_q == StFlushDone);

endmodule

// File: tb/tb_cu_setup_sequencer.sv
// Randomized self-checking bench for cu_setup_sequencer with a transaction-level
// memory model: every handshake pushes the expected word address, responses pop
// in order, and each response index r must appear as channel r/8, index r%8.
module tb_cu_setup_sequencer;
    import cu_setup_sequencer_pkg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        start_in;
    logic        pause_in;
    logic [63:0] cfg_base_addr_in;
    logic [15:0] cfg_num_words_in;
    logic [3:0]  cfg_valid_out;
    logic [2:0]  cfg_index_out;
    logic [31:0] cfg_data_out;
    logic        busy_out, done_out, error_out;
    logic [9:0]  state_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    cu_setup_sequencer_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) mem_if ();

    cu_setup_sequencer #(
        .ADDR_WIDTH(64), .DATA_WIDTH(32), .NUM_CHANNELS(4),
        .WORDS_PER_CHANNEL(8), .MAX_OUTSTANDING(16), .COUNT_WIDTH(16)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .start_in         (start_in),
        .pause_in         (pause_in),
        .cfg_base_addr_in (cfg_base_addr_in),
        .cfg_num_words_in (cfg_num_words_in),
        .mem              (mem_if),
        .cfg_valid_out    (cfg_valid_out),
        .cfg_index_out    (cfg_index_out),
        .cfg_data_out     (cfg_data_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .error_out        (error_out),
        .state_out        (state_out)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    // One complete fetch with a random memory; optional directed features:
    // stall_first: hold ready low for the first N valid cycles
    // hold_cyc:    withhold responses until that cycle, release one, wait 20 cycles
    // pause_at:    hold pause for 20 cycles once that many words were issued
    task automatic run_op(input int unsigned nwords, input logic [63:0] base,
                          input int unsigned rdy_pct, input int unsigned rsp_pct,
                          input int unsigned pause_pct, input int unsigned stall_first,
                          input int unsigned hold_cyc, input int unsigned pause_at);
        int unsigned exp_n, issued, delivered, cyc, stalls, rsp_idx, pause_start, pause_issued;
        logic [63:0] pend[$];
        logic [31:0] rsp_dat;
        bit done_seen, prev_req, prev_hs, prev_pause, rsp_drv, rsp_ok, pause_set;
        exp_n = (nwords > 32) ? 32 : nwords;
        issued = 0; delivered = 0; cyc = 0; stalls = 0; rsp_idx = 0;
        pause_start = 0; pause_issued = 0; rsp_dat = '0;
        done_seen = 0; prev_req = 0; prev_hs = 0; prev_pause = 0; rsp_drv = 0; pause_set = 0;

        @(negedge ap_clk);
        cfg_base_addr_in = base;
        cfg_num_words_in = 16'(nwords);
        start_in = 1'b1;
        @(negedge ap_clk);
        start_in = 1'b0;
        check_val("start_err_clr", error_out, 0);

        while (!done_seen && cyc < 4000) begin
            if (rsp_drv) begin
                check_val("cfg_valid", cfg_valid_out, 4'b0001 << (rsp_idx / 8));
                check_val("cfg_index", cfg_index_out, rsp_idx % 8);
                check_val("cfg_data", cfg_data_out, rsp_dat);
            end else begin
                check_val("cfg_quiet", cfg_valid_out, 0);
            end

            if (done_out) begin
                done_seen = 1;
                check_val("done_issued", issued, exp_n);
                check_val("done_delivered", delivered, exp_n);
                check_val("done_inflight", pend.size(), 0);
                check_val("done_error", error_out, 0);
                check_val("done_busy", busy_out, 0);
                rsp_drv = 0;
                pause_in = 1'b0;
                mem_if.req_ready_in = 1'b0;
                mem_if.resp_valid_in = 1'b0;
            end else begin
                check_val("busy", busy_out, 1);
                if (prev_req && !prev_hs) check_val("req_hold", mem_if.req_valid_out, 1);
                if (prev_pause && !prev_req) check_val("req_paused", mem_if.req_valid_out, 0);
                if (mem_if.req_valid_out) begin
                    check_val("req_addr", mem_if.req_addr_out, base + 64'(issued) * 64'd4);
                    check_val("req_count", issued < exp_n, 1);
                    check_val("req_credit", pend.size() < 16, 1);
                end
                if (hold_cyc != 0 && cyc == hold_cyc) begin
                    check_val("credit_full_issued", issued, 16);
                    check_val("credit_full_valid", mem_if.req_valid_out, 0);
                end
                if (hold_cyc != 0 && cyc == hold_cyc + 20) begin
                    check_val("credit_one_more", issued, 17);
                    check_val("credit_refull_valid", mem_if.req_valid_out, 0);
                end
                if (pause_set && cyc == pause_start + 2) begin
                    check_val("pause_state", state_out, ST_REQ_PAUSE);
                    pause_issued = issued;
                end
                if (pause_set && cyc == pause_start + 19) begin
                    check_val("pause_no_req", issued, pause_issued);
                    check_val("pause_state_held", state_out, ST_REQ_PAUSE);
                end

                if (pause_at != 0 && !pause_set && issued == pause_at) begin
                    pause_set = 1;
                    pause_start = cyc;
                end
                if (pause_set && cyc < pause_start + 20) pause_in = 1'b1;
                else pause_in = ($urandom_range(99) < pause_pct);

                if (mem_if.req_valid_out && stalls < stall_first) begin
                    mem_if.req_ready_in = 1'b0;
                    stalls++;
                end else begin
                    mem_if.req_ready_in = ($urandom_range(99) < rdy_pct);
                end
                prev_req = mem_if.req_valid_out;
                prev_hs = prev_req && mem_if.req_ready_in;
                prev_pause = pause_in;

                rsp_drv = 0;
                rsp_ok = (pend.size() > 0) && ($urandom_range(99) < rsp_pct);
                if (hold_cyc != 0 && cyc < hold_cyc + 20) rsp_ok = (cyc == hold_cyc) && (pend.size() > 0);
                if (rsp_ok) begin
                    rsp_drv = 1;
                    rsp_idx = delivered;
                    rsp_dat = word_of(pend.pop_front());
                    delivered++;
                end
                mem_if.resp_valid_in = rsp_drv;
                mem_if.resp_data_in = rsp_drv ? rsp_dat : $urandom;
                if (prev_hs) begin
                    pend.push_back(base + 64'(issued) * 64'd4);
                    issued++;
                end
            end
            @(negedge ap_clk);
            cyc++;
        end
        if (!done_seen) check_val("timeout_done", done_seen, 1);
        check_val("after_done_state", state_out, ST_IDLE);
        check_val("after_done_pulse", done_out, 0);
    endtask

    logic [9:0] zero_seq [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_seq[0] = ST_REQ_START;  zero_seq[1] = ST_REQ_DONE;  zero_seq[2] = ST_FLUSH_START;
        zero_seq[3] = ST_FLUSH_BUSY; zero_seq[4] = ST_FLUSH_DONE; zero_seq[5] = ST_IDLE;
        ap_rst_n = 1'b0; start_in = 1'b0; pause_in = 1'b0;
        cfg_base_addr_in = '0; cfg_num_words_in = '0;
        mem_if.req_ready_in = 1'b0; mem_if.resp_valid_in = 1'b0; mem_if.resp_data_in = '0;

        repeat (2) @(negedge ap_clk);
        check_val("rst_state", state_out, ST_RESET);
        check_val("rst_outputs", {mem_if.req_valid_out, cfg_valid_out, busy_out, done_out,
                  error_out}, 0);
        check_val("rst_addr", mem_if.req_addr_out, 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check_val("idle_state", state_out, ST_IDLE);

        // Zero-length block walks straight through to done.
        cfg_base_addr_in = 64'h4000; cfg_num_words_in = 16'd0; start_in = 1'b1;
        @(negedge ap_clk);
        start_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_val("zero_state", state_out, zero_seq[i]);
            check_val("zero_req", mem_if.req_valid_out, 0);
            check_val("zero_done", done_out, (i == 4));
            @(negedge ap_clk);
        end

        run_op(32, 64'h1000, 100, 100, 0, 0, 0, 0);
        run_op(5, 64'h1000, 100, 100, 0, 3, 0, 0);
        run_op(32, 64'h2000, 100, 100, 0, 0, 40, 0);
        run_op(32, 64'h1000, 100, 100, 0, 0, 0, 10);
        run_op(100, 64'h3000, 100, 100, 0, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin
            run_op($urandom_range(0, 40), {$urandom, $urandom} & ~64'h3,
                   $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 20),
                   0, 0, 0);
        end

        // Reset in the middle of a fetch, then a late response in IDLE.
        @(negedge ap_clk);
        cfg_base_addr_in = 64'h5000; cfg_num_words_in = 16'd32; start_in = 1'b1;
        @(negedge ap_clk);
        start_in = 1'b0;
        mem_if.req_ready_in = 1'b1;
        repeat (8) @(negedge ap_clk);
        check_val("midop_state", state_out, ST_REQ_BUSY);
        #2 ap_rst_n = 1'b0;
        #1;
        check_val("midop_rst_state", state_out, ST_RESET);
        check_val("midop_rst_outputs", {mem_if.req_valid_out, cfg_valid_out, busy_out,
                  done_out, error_out}, 0);
        check_val("midop_rst_addr", mem_if.req_addr_out, 0);
        @(negedge ap_clk);
        mem_if.req_ready_in = 1'b0;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check_val("midop_idle", state_out, ST_IDLE);
        mem_if.resp_valid_in = 1'b1;
        mem_if.resp_data_in = 32'hDEAD_BEEF;
        @(negedge ap_clk);
        mem_if.resp_valid_in = 1'b0;
        check_val("late_resp_error", error_out, 1);
        check_val("late_resp_no_cfg", cfg_valid_out, 0);

        run_op(12, 64'h6000, 80, 80, 5, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
